// File: rtl/keypad_emulator_if.sv
// keypad_emulator_if -- keystroke command channel for keypad_emulator.
//   cmd_valid  master->slave  keystroke request
//   cmd_ready  slave->master  emulator idle; request taken when both are high
//   cmd_row    master->slave  row index of the key to press
//   cmd_col    master->slave  column index of the key to press
//   cmd_hold   master->slave  settled-pressed duration in cycles (0 acts as 1)
interface keypad_emulator_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_row;
  logic [1:0]  cmd_col;
  logic [15:0] cmd_hold;

  modport master (output cmd_valid, cmd_row, cmd_col, cmd_hold, input cmd_ready);
  modport slave  (input cmd_valid, cmd_row, cmd_col, cmd_hold, output cmd_ready);
endinterface

// File: rtl/keypad_emulator.sv
// keypad_emulator -- emulates one mechanical key of a 4x4 matrix keypad,
// including contact bounce on press and release and a settled gap afterwards.
//   clk             single clock, rising edge
//   rst             synchronous active-high reset
//   cmd             keystroke command channel (slave side)
//   keypad_col_in   column drive from the scanner (active-high)
//   keypad_row_out  row return to the scanner (active-high, 0 = no key)
//   abort           cancel the keystroke in progress (jumps to the gap)
//   busy            high whenever a keystroke is in progress
//   done            one-cycle pulse when a keystroke completes or is aborted
module keypad_emulator #(
  parameter int BOUNCE_TICKS = 8,
  parameter int BOUNCE_EDGES = 3,
  parameter int GAP_TICKS    = 16
) (
  input  logic              clk,
  input  logic              rst,
  keypad_emulator_if.slave  cmd,
  input  logic [3:0]        keypad_col_in,
  output logic [3:0]        keypad_row_out,
  input  logic              abort,
  output logic              busy,
  output logic              done
);

  typedef enum logic [2:0] {
    IDLE,
    PRESS_BOUNCE,
    HOLD,
    RELEASE_BOUNCE,
    GAP
  } state_t;

  localparam logic [15:0] TICK_LAST = 16'(BOUNCE_TICKS - 1);
  localparam logic [16:0] TOGGLES   = 17'(2 * BOUNCE_EDGES);
  localparam logic [15:0] GAP_LAST  = 16'(GAP_TICKS - 1);

  state_t      state_q, state_d;
  logic        contact_q, contact_d;
  logic [15:0] cnt_q, cnt_d;
  logic [16:0] toggles_q, toggles_d;
  logic [1:0]  row_q, row_d;
  logic [1:0]  col_q, col_d;
  logic [15:0] hold_q, hold_d;
  logic        done_q, done_d;

  logic [15:0] hold_last;
  logic        tick_expired;
  logic        bounce_done;

  // A hold of 0 behaves as a hold of 1 cycle.
  assign hold_last    = (hold_q == 16'd0) ? 16'd0 : hold_q - 16'd1;
  assign tick_expired = (cnt_q == TICK_LAST);
  // Bounce phase ends on the cycle of its final toggle, or immediately
  // when no bounce pulses are configured.
  assign bounce_done  = (TOGGLES == 17'd0) ||
                        (tick_expired && (toggles_q + 17'd1 == TOGGLES));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      contact_q <= 1'b0;
      cnt_q     <= 16'd0;
      toggles_q <= 17'd0;
      row_q     <= 2'd0;
      col_q     <= 2'd0;
      hold_q    <= 16'd0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      contact_q <= contact_d;
      cnt_q     <= cnt_d;
      toggles_q <= toggles_d;
      row_q     <= row_d;
      col_q     <= col_d;
      hold_q    <= hold_d;
      done_q    <= done_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    contact_d = contact_q;
    cnt_d     = cnt_q + 16'd1;
    toggles_d = toggles_q;
    row_d     = row_q;
    col_d     = col_q;
    hold_d    = hold_q;
    done_d    = 1'b0;

    case (state_q)
      IDLE: begin
        cnt_d = 16'd0;
        if (cmd.cmd_valid) begin
          row_d     = cmd.cmd_row;
          col_d     = cmd.cmd_col;
          hold_d    = cmd.cmd_hold;
          state_d   = PRESS_BOUNCE;
          contact_d = 1'b1;
          toggles_d = 17'd0;
        end
      end
      PRESS_BOUNCE: begin
        if (bounce_done) begin
          state_d   = HOLD;
          contact_d = 1'b1;
          cnt_d     = 16'd0;
          toggles_d = 17'd0;
        end else if (tick_expired) begin
          contact_d = ~contact_q;
          cnt_d     = 16'd0;
          toggles_d = toggles_q + 17'd1;
        end
      end
      HOLD: begin
        if (cnt_q == hold_last) begin
          state_d   = RELEASE_BOUNCE;
          contact_d = 1'b0;
          cnt_d     = 16'd0;
          toggles_d = 17'd0;
        end
      end
      RELEASE_BOUNCE: begin
        if (bounce_done) begin
          state_d   = GAP;
          contact_d = 1'b0;
          cnt_d     = 16'd0;
          toggles_d = 17'd0;
        end else if (tick_expired) begin
          contact_d = ~contact_q;
          cnt_d     = 16'd0;
          toggles_d = toggles_q + 17'd1;
        end
      end
      GAP: begin
        contact_d = 1'b0;
        if (cnt_q == GAP_LAST) begin
          state_d = IDLE;
          cnt_d   = 16'd0;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d   = IDLE;
        contact_d = 1'b0;
        cnt_d     = 16'd0;
        toggles_d = 17'd0;
      end
    endcase

    // Abort outranks any counter expiry this cycle, including the gap's own
    // completion, so a late abort restarts the gap instead of finishing.
    if (abort && (state_q != IDLE)) begin
      state_d   = GAP;
      contact_d = 1'b0;
      cnt_d     = 16'd0;
      toggles_d = 17'd0;
      done_d    = 1'b0;
    end
  end

  assign keypad_row_out = (contact_q && keypad_col_in[col_q]) ? (4'b0001 << row_q) : 4'b0000;
  assign cmd.cmd_ready  = (state_q == IDLE);
  assign busy           = (state_q != IDLE);
  assign done           = done_q;

endmodule

// File: tb/tb_keypad_emulator.sv
module tb_keypad_emulator;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] col_in, row_out;
  logic       abort, busy, done;
  logic [3:0] nb_col_in, nb_row_out;
  logic       nb_abort, nb_busy, nb_done;

  int tests = 0;
  int fails = 0;

  keypad_emulator_if c_if();
  keypad_emulator_if nb_if();

  always #5 clk = ~clk;

  keypad_emulator u_dut (
    .clk            (clk),
    .rst            (rst),
    .cmd            (c_if),
    .keypad_col_in  (col_in),
    .keypad_row_out (row_out),
    .abort          (abort),
    .busy           (busy),
    .done           (done)
  );

  keypad_emulator #(.BOUNCE_TICKS(8), .BOUNCE_EDGES(0), .GAP_TICKS(16)) u_nb (
    .clk            (clk),
    .rst            (rst),
    .cmd            (nb_if),
    .keypad_col_in  (nb_col_in),
    .keypad_row_out (nb_row_out),
    .abort          (nb_abort),
    .busy           (nb_busy),
    .done           (nb_done)
  );

  // Expected contact level k cycles after acceptance for the default
  // parameters (8-cycle ticks, 3 pulses, 16-cycle gap), effective hold h.
  function automatic logic exp_contact(input int k, input int h);
    if (k < 48)          return ((k / 8) % 2) == 0;
    if (k < 48 + h)      return 1'b1;
    if (k < 96 + h)      return (((k - 48 - h) / 8) % 2) == 1;
    return 1'b0;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_cmd(input logic [1:0] r, input logic [1:0] c, input logic [15:0] h);
    c_if.cmd_valid = 1'b1;
    c_if.cmd_row   = r;
    c_if.cmd_col   = c;
    c_if.cmd_hold  = h;
    step();
    c_if.cmd_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    col_in = 4'b1111;
    step();
    step();
    tests++;
    if (row_out !== 4'b0000) begin fails++; $display("FAIL reset_row_out got=%b want=0000", row_out); end
    tests++;
    if (c_if.cmd_ready !== 1'b1) begin fails++; $display("FAIL reset_ready got=%b want=1", c_if.cmd_ready); end
    tests++;
    if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got=%b want=0", busy); end
    tests++;
    if (done !== 1'b0) begin fails++; $display("FAIL reset_done got=%b want=0", done); end
    rst = 1'b0;
    step();
    tests++;
    if (row_out !== 4'b0000 || busy !== 1'b0 || c_if.cmd_ready !== 1'b1 || done !== 1'b0) begin
      fails++;
      $display("FAIL idle_after_reset row=%b busy=%b ready=%b done=%b want 0000/0/1/0",
               row_out, busy, c_if.cmd_ready, done);
    end
    $display("[TB] reset checked");
  endtask

  task automatic test_full_press();
    logic [3:0] exp;
    col_in = 4'b0010;
    send_cmd(2'd2, 2'd1, 16'd100);
    for (int k = 0; k < 212; k++) begin
      exp = exp_contact(k, 100) ? 4'b0100 : 4'b0000;
      tests++;
      if (row_out !== exp || busy !== 1'b1 || c_if.cmd_ready !== 1'b0 || done !== 1'b0) begin
        fails++;
        $display("FAIL full_press k=%0d row=%b busy=%b ready=%b done=%b want row=%b busy=1 ready=0 done=0",
                 k, row_out, busy, c_if.cmd_ready, done, exp);
      end
      step();
    end
    tests++;
    if (done !== 1'b1 || c_if.cmd_ready !== 1'b1 || busy !== 1'b0) begin
      fails++;
      $display("FAIL full_press_done done=%b ready=%b busy=%b want 1/1/0", done, c_if.cmd_ready, busy);
    end
    step();
    tests++;
    if (done !== 1'b0) begin fails++; $display("FAIL full_press_done_pulse got=%b want=0", done); end
    $display("[TB] keystroke row=2 col=1 hold=100 complete");
  endtask

  task automatic test_hold_zero();
    logic [3:0] exp;
    col_in = 4'b1001;
    send_cmd(2'd3, 2'd0, 16'd0);
    for (int k = 0; k < 113; k++) begin
      exp = exp_contact(k, 1) ? 4'b1000 : 4'b0000;
      tests++;
      if (row_out !== exp || busy !== 1'b1 || done !== 1'b0) begin
        fails++;
        $display("FAIL hold_zero k=%0d row=%b busy=%b done=%b want row=%b busy=1 done=0",
                 k, row_out, busy, done, exp);
      end
      step();
    end
    tests++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      fails++;
      $display("FAIL hold_zero_done done=%b busy=%b want 1/0", done, busy);
    end
    step();
    $display("[TB] keystroke row=3 col=0 hold=0 complete");
  endtask

  task automatic test_col_rotation();
    logic [3:0] exp;
    logic [3:0] rot;
    col_in = 4'b0001;
    send_cmd(2'd2, 2'd1, 16'd100);
    for (int k = 0; k < 212; k++) begin
      rot = 4'b0001 << ((k / 25) % 4);
      col_in = rot;
      #1;
      exp = (exp_contact(k, 100) && rot == 4'b0010) ? 4'b0100 : 4'b0000;
      tests++;
      if (row_out !== exp) begin
        fails++;
        $display("FAIL col_rotation k=%0d col_in=%b row=%b want=%b", k, col_in, row_out, exp);
      end
      step();
    end
    tests++;
    if (done !== 1'b1) begin fails++; $display("FAIL col_rotation_done got=%b want=1", done); end
    step();
    $display("[TB] keystroke with rotating columns complete");
  endtask

  task automatic test_abort_hold();
    logic [3:0] exp;
    col_in = 4'b0010;
    send_cmd(2'd2, 2'd1, 16'd100);
    for (int k = 0; k < 70; k++) begin
      // A competing request with different data is held during the keystroke.
      if (k == 10) begin
        c_if.cmd_valid = 1'b1;
        c_if.cmd_row   = 2'd0;
        c_if.cmd_col   = 2'd0;
        c_if.cmd_hold  = 16'd5;
      end
      if (k == 65) c_if.cmd_valid = 1'b0;
      abort = (k == 53);
      exp = (k <= 53 && exp_contact(k, 100)) ? 4'b0100 : 4'b0000;
      tests++;
      if (row_out !== exp || busy !== 1'b1 || c_if.cmd_ready !== 1'b0 || done !== 1'b0) begin
        fails++;
        $display("FAIL abort_hold k=%0d row=%b busy=%b ready=%b done=%b want row=%b busy=1 ready=0 done=0",
                 k, row_out, busy, c_if.cmd_ready, done, exp);
      end
      step();
    end
    abort = 1'b0;
    tests++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      fails++;
      $display("FAIL abort_hold_done done=%b busy=%b want 1/0", done, busy);
    end
    step();
    tests++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      fails++;
      $display("FAIL abort_hold_no_second busy=%b done=%b want 0/0", busy, done);
    end
    $display("[TB] keystroke aborted in hold");
  endtask

  task automatic test_abort_gap();
    logic [3:0] exp;
    col_in = 4'b0010;
    send_cmd(2'd2, 2'd1, 16'd100);
    for (int k = 0; k < 43; k++) begin
      // k=15 coincides with a toggle expiry; k=26 lands mid-gap.
      abort = (k == 15) || (k == 26);
      exp = (k < 16 && exp_contact(k, 100)) ? 4'b0100 : 4'b0000;
      tests++;
      if (row_out !== exp || busy !== 1'b1 || done !== 1'b0) begin
        fails++;
        $display("FAIL abort_gap k=%0d row=%b busy=%b done=%b want row=%b busy=1 done=0",
                 k, row_out, busy, done, exp);
      end
      step();
    end
    abort = 1'b0;
    tests++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      fails++;
      $display("FAIL abort_gap_done done=%b busy=%b want 1/0", done, busy);
    end
    step();
    abort = 1'b1;
    step();
    step();
    tests++;
    if (busy !== 1'b0 || c_if.cmd_ready !== 1'b1 || done !== 1'b0 || row_out !== 4'b0000) begin
      fails++;
      $display("FAIL abort_idle busy=%b ready=%b done=%b row=%b want 0/1/0/0000",
               busy, c_if.cmd_ready, done, row_out);
    end
    abort = 1'b0;
    $display("[TB] keystroke aborted in bounce and gap");
  endtask

  task automatic test_reset_mid();
    logic [3:0] exp;
    col_in = 4'b0010;
    send_cmd(2'd2, 2'd1, 16'd100);
    for (int k = 0; k <= 20; k++) begin
      exp = exp_contact(k, 100) ? 4'b0100 : 4'b0000;
      tests++;
      if (row_out !== exp) begin
        fails++;
        $display("FAIL reset_mid_pre k=%0d row=%b want=%b", k, row_out, exp);
      end
      if (k < 20) step();
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    tests++;
    if (row_out !== 4'b0000 || c_if.cmd_ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
      fails++;
      $display("FAIL reset_mid row=%b ready=%b busy=%b done=%b want 0000/1/0/0",
               row_out, c_if.cmd_ready, busy, done);
    end
    for (int k = 0; k < 30; k++) begin
      step();
      tests++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        fails++;
        $display("FAIL reset_mid_quiet k=%0d done=%b busy=%b want 0/0", k, done, busy);
      end
    end
    // Reset coinciding with a handshake drops the command.
    c_if.cmd_valid = 1'b1;
    rst = 1'b1;
    step();
    rst = 1'b0;
    c_if.cmd_valid = 1'b0;
    step();
    tests++;
    if (busy !== 1'b0 || row_out !== 4'b0000 || c_if.cmd_ready !== 1'b1) begin
      fails++;
      $display("FAIL reset_handshake busy=%b row=%b ready=%b want 0/0000/1", busy, row_out, c_if.cmd_ready);
    end
    $display("[TB] reset during press bounce and during handshake");
  endtask

  task automatic test_back_to_back();
    logic [3:0] exp;
    col_in = 4'b0100;
    c_if.cmd_valid = 1'b1;
    c_if.cmd_row   = 2'd1;
    c_if.cmd_col   = 2'd2;
    c_if.cmd_hold  = 16'd3;
    step();
    for (int k = 0; k < 115; k++) begin
      exp = exp_contact(k, 3) ? 4'b0010 : 4'b0000;
      tests++;
      if (row_out !== exp || busy !== 1'b1 || done !== 1'b0) begin
        fails++;
        $display("FAIL b2b_first k=%0d row=%b busy=%b done=%b want row=%b busy=1 done=0",
                 k, row_out, busy, done, exp);
      end
      step();
    end
    tests++;
    if (done !== 1'b1 || c_if.cmd_ready !== 1'b1 || row_out !== 4'b0000) begin
      fails++;
      $display("FAIL b2b_done done=%b ready=%b row=%b want 1/1/0000", done, c_if.cmd_ready, row_out);
    end
    step();
    c_if.cmd_valid = 1'b0;
    for (int k = 0; k < 115; k++) begin
      exp = exp_contact(k, 3) ? 4'b0010 : 4'b0000;
      tests++;
      if (row_out !== exp || busy !== 1'b1 || done !== 1'b0) begin
        fails++;
        $display("FAIL b2b_second k=%0d row=%b busy=%b done=%b want row=%b busy=1 done=0",
                 k, row_out, busy, done, exp);
      end
      step();
    end
    tests++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      fails++;
      $display("FAIL b2b_second_done done=%b busy=%b want 1/0", done, busy);
    end
    step();
    $display("[TB] back-to-back keystrokes complete");
  endtask

  task automatic test_no_bounce();
    logic [3:0] exp;
    nb_col_in = 4'b1000;
    nb_if.cmd_valid = 1'b1;
    nb_if.cmd_row   = 2'd0;
    nb_if.cmd_col   = 2'd3;
    nb_if.cmd_hold  = 16'd0;
    step();
    nb_if.cmd_valid = 1'b0;
    for (int k = 0; k < 19; k++) begin
      exp = (k < 2) ? 4'b0001 : 4'b0000;
      tests++;
      if (nb_row_out !== exp || nb_busy !== 1'b1 || nb_done !== 1'b0) begin
        fails++;
        $display("FAIL no_bounce k=%0d row=%b busy=%b done=%b want row=%b busy=1 done=0",
                 k, nb_row_out, nb_busy, nb_done, exp);
      end
      step();
    end
    tests++;
    if (nb_done !== 1'b1 || nb_busy !== 1'b0) begin
      fails++;
      $display("FAIL no_bounce_done done=%b busy=%b want 1/0", nb_done, nb_busy);
    end
    step();
    $display("[TB] keystroke without bounce complete");
  endtask

  initial begin
    rst = 1'b1;
    abort = 1'b0;
    nb_abort = 1'b0;
    col_in = 4'b0000;
    nb_col_in = 4'b0000;
    c_if.cmd_valid = 1'b0;
    c_if.cmd_row = 2'd0;
    c_if.cmd_col = 2'd0;
    c_if.cmd_hold = 16'd0;
    nb_if.cmd_valid = 1'b0;
    nb_if.cmd_row = 2'd0;
    nb_if.cmd_col = 2'd0;
    nb_if.cmd_hold = 16'd0;

    test_reset();
    test_full_press();
    test_hold_zero();
    test_col_rotation();
    test_abort_hold();
    test_abort_gap();
    test_reset_mid();
    test_back_to_back();
    test_no_bounce();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
